// File: rtl/sodor_mem_arbiter_if.sv
// Bus bundle joining the Core imem/dmem ports and the backing-memory port to the arbiter.
interface sodor_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              io_imem_req_valid;
  logic              io_imem_req_ready;
  logic [ADDR_W-1:0] io_imem_req_bits_addr;
  logic              io_imem_resp_valid;
  logic [DATA_W-1:0] io_imem_resp_bits_data;

  logic              io_dmem_req_valid;
  logic              io_dmem_req_ready;
  logic [ADDR_W-1:0] io_dmem_req_bits_addr;
  logic [DATA_W-1:0] io_dmem_req_bits_data;
  logic              io_dmem_req_bits_fcn;
  logic [2:0]        io_dmem_req_bits_typ;
  logic              io_dmem_resp_valid;
  logic [DATA_W-1:0] io_dmem_resp_bits_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_bits_addr;
  logic [DATA_W-1:0] mem_req_bits_data;
  logic              mem_req_bits_fcn;
  logic [2:0]        mem_req_bits_typ;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_bits_data;

  // Arbiter side
  modport slave (
    input  io_imem_req_valid, io_imem_req_bits_addr,
    output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_bits_data,
    input  io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
    input  io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
    output io_dmem_req_ready, io_dmem_resp_valid, io_dmem_resp_bits_data,
    output mem_req_valid, mem_req_bits_addr, mem_req_bits_data, mem_req_bits_fcn, mem_req_bits_typ,
    input  mem_req_ready, mem_resp_valid, mem_resp_bits_data
  );

  // Core + memory side
  modport master (
    output io_imem_req_valid, io_imem_req_bits_addr,
    input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_bits_data,
    output io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
    output io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
    input  io_dmem_req_ready, io_dmem_resp_valid, io_dmem_resp_bits_data,
    input  mem_req_valid, mem_req_bits_addr, mem_req_bits_data, mem_req_bits_fcn, mem_req_bits_typ,
    output mem_req_ready, mem_resp_valid, mem_resp_bits_data
  );
endinterface

// File: rtl/sodor_mem_arbiter.sv
// Shares one single-port memory between imem fetch and dmem load/store, one transaction in flight,
// dmem priority with a starvation guard that forces imem through after STARVE_LIMIT lost conflicts.
module sodor_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clock,
  input  logic               reset,
  sodor_mem_arbiter_if.slave bus,
  output logic               io_err_spurious
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_DMEM = 1'b0, OWN_IMEM = 1'b1} owner_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              fcn;
    logic [2:0]        typ;
  } mreq_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  mreq_t            req_q, req_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             conflict, gnt_imem, gnt_dmem, resp_fire, err_q;

  // Grant is purely combinational on valid so ready rises in the same cycle as the grant edge.
  always_comb begin
    conflict = bus.io_imem_req_valid && bus.io_dmem_req_valid;
    gnt_imem = 1'b0;
    gnt_dmem = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.io_imem_req_valid && (!bus.io_dmem_req_valid || starve_cnt == LIMIT))
        gnt_imem = 1'b1;
      else if (bus.io_dmem_req_valid)
        gnt_dmem = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    req_nxt    = req_q;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (gnt_imem) begin
          req_nxt    = '{addr: bus.io_imem_req_bits_addr, data: '0, fcn: 1'b0, typ: 3'b000};
          owner_nxt  = OWN_IMEM;
          starve_nxt = '0;
          state_nxt  = REQ;
        end else if (gnt_dmem) begin
          req_nxt   = '{addr: bus.io_dmem_req_bits_addr, data: bus.io_dmem_req_bits_data,
                        fcn: bus.io_dmem_req_bits_fcn, typ: bus.io_dmem_req_bits_typ};
          owner_nxt = OWN_DMEM;
          if (conflict && starve_cnt != LIMIT) starve_nxt = starve_cnt + 1'b1;
          state_nxt = REQ;
        end
      end
      REQ:     if (bus.mem_req_ready) state_nxt = RESP;
      RESP:    if (bus.mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_DMEM;
      req_q      <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      req_q      <= req_nxt;
      starve_cnt <= starve_nxt;
      // A response with nothing outstanding is dropped but remembered.
      if (bus.mem_resp_valid && state != RESP) err_q <= 1'b1;
    end
  end

  assign resp_fire = (state == RESP) && bus.mem_resp_valid;

  assign bus.io_imem_req_ready      = gnt_imem;
  assign bus.io_dmem_req_ready      = gnt_dmem;
  assign bus.io_imem_resp_valid     = resp_fire && owner == OWN_IMEM;
  assign bus.io_dmem_resp_valid     = resp_fire && owner == OWN_DMEM;
  assign bus.io_imem_resp_bits_data = (resp_fire && owner == OWN_IMEM) ? bus.mem_resp_bits_data : '0;
  assign bus.io_dmem_resp_bits_data = (resp_fire && owner == OWN_DMEM) ? bus.mem_resp_bits_data : '0;

  assign bus.mem_req_valid     = (state == REQ);
  assign bus.mem_req_bits_addr = req_q.addr;
  assign bus.mem_req_bits_data = req_q.data;
  assign bus.mem_req_bits_fcn  = req_q.fcn;
  assign bus.mem_req_bits_typ  = req_q.typ;

  assign io_err_spurious = err_q;
endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Scoreboard bench for sodor_mem_arbiter: requester drivers, a memory model, and a response monitor.
module tb_sodor_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic err;

  sodor_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  sodor_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset), .bus(bus), .io_err_spurious(err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic fcn; logic [2:0] typ; } req_t;
  typedef struct { logic is_d; logic [31:0] data; logic chk; } rsp_t;

  logic [31:0] imem_q[$];
  req_t        dmem_q[$];
  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  int          gnt_cyc[$];
  logic [31:0] mem_arr [logic [31:0]];

  int   chk_total = 0, chk_pass = 0;
  int   cyc = 0;
  bit   rand_mode = 1'b0, spur_req = 1'b0, prev_mvld = 1'b0;
  int   stall_left = 0, resp_delay = 1, rsp_wait = 0;
  logic [31:0] rsp_data = '0;
  int   imem_gnt_cyc = 0, imem_resp_cyc = 0, mreq_cyc = 0, mreq_vld_cycles = 0;
  int   imem_rsp_cnt = 0, dmem_rsp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] out_flags();
    return {52'b0, bus.io_imem_req_ready, bus.io_imem_resp_valid, |bus.io_imem_resp_bits_data,
            bus.io_dmem_req_ready, bus.io_dmem_resp_valid, |bus.io_dmem_resp_bits_data,
            bus.mem_req_valid, |bus.mem_req_bits_addr, |bus.mem_req_bits_data,
            bus.mem_req_bits_fcn, |bus.mem_req_bits_typ, err};
  endfunction

  task automatic expect_txn(input logic is_d, input logic [31:0] a, input logic [31:0] d,
                            input logic f, input logic [2:0] t, input logic [31:0] rd, input logic chk);
    exp_req.push_back('{addr: a, data: d, fcn: f, typ: t});
    exp_rsp.push_back('{is_d: is_d, data: rd, chk: chk});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    int pending;
    n = 0;
    pending = imem_q.size() + dmem_q.size() + exp_req.size() + exp_rsp.size() + rsp_wait;
    while (pending != 0) begin
      @(negedge clock);
      n++;
      pending = imem_q.size() + dmem_q.size() + exp_req.size() + exp_rsp.size() + rsp_wait;
      if (pending != 0 && n >= budget) begin
        check({name, "_timeout"}, 64'(pending), 64'd0);
        imem_q.delete(); dmem_q.delete(); exp_req.delete(); exp_rsp.delete();
        rsp_wait = 0;
        pending = 0;
      end
    end
    @(negedge clock);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // imem requester: holds valid and address until accepted
  initial begin
    bus.io_imem_req_valid = 1'b0;
    bus.io_imem_req_bits_addr = '0;
    forever begin
      @(posedge clock); #1;
      if (rand_mode) begin
        bus.io_imem_req_valid = 1'($urandom_range(0, 1));
        bus.io_imem_req_bits_addr = $urandom;
      end else if (imem_q.size() > 0) begin
        bus.io_imem_req_valid = 1'b1;
        bus.io_imem_req_bits_addr = imem_q[0];
      end else begin
        bus.io_imem_req_valid = 1'b0;
        bus.io_imem_req_bits_addr = '0;
      end
      @(negedge clock);
      if (!rand_mode && bus.io_imem_req_valid && bus.io_imem_req_ready) begin
        void'(imem_q.pop_front());
        imem_gnt_cyc = cyc;
        gnt_cyc.push_back(cyc);
      end
    end
  end

  // dmem requester
  initial begin
    bus.io_dmem_req_valid = 1'b0;
    bus.io_dmem_req_bits_addr = '0;
    bus.io_dmem_req_bits_data = '0;
    bus.io_dmem_req_bits_fcn = 1'b0;
    bus.io_dmem_req_bits_typ = '0;
    forever begin
      @(posedge clock); #1;
      if (rand_mode) begin
        bus.io_dmem_req_valid = 1'($urandom_range(0, 1));
        bus.io_dmem_req_bits_addr = $urandom;
        bus.io_dmem_req_bits_data = $urandom;
        bus.io_dmem_req_bits_fcn = 1'($urandom_range(0, 1));
        bus.io_dmem_req_bits_typ = 3'($urandom_range(0, 7));
      end else if (dmem_q.size() > 0) begin
        bus.io_dmem_req_valid = 1'b1;
        bus.io_dmem_req_bits_addr = dmem_q[0].addr;
        bus.io_dmem_req_bits_data = dmem_q[0].data;
        bus.io_dmem_req_bits_fcn = dmem_q[0].fcn;
        bus.io_dmem_req_bits_typ = dmem_q[0].typ;
      end else begin
        bus.io_dmem_req_valid = 1'b0;
        bus.io_dmem_req_bits_addr = '0;
        bus.io_dmem_req_bits_data = '0;
        bus.io_dmem_req_bits_fcn = 1'b0;
        bus.io_dmem_req_bits_typ = '0;
      end
      @(negedge clock);
      if (!rand_mode && bus.io_dmem_req_valid && bus.io_dmem_req_ready) begin
        void'(dmem_q.pop_front());
        gnt_cyc.push_back(cyc);
      end
    end
  end

  // Backing memory: optional ready stall, response resp_delay cycles after acceptance
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_bits_data = '0;
    forever begin
      @(posedge clock); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_bits_data = '0;
      if (rand_mode) begin
        bus.mem_req_ready = 1'($urandom_range(0, 1));
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_resp_bits_data = $urandom;
      end else begin
        if (rsp_wait > 0) begin
          rsp_wait--;
          if (rsp_wait == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_bits_data = rsp_data;
          end
        end
        if (spur_req) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_bits_data = 32'h0BAD_F00D;
          spur_req = 1'b0;
        end
        if (bus.mem_req_valid && stall_left > 0) begin
          bus.mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          bus.mem_req_ready = bus.mem_req_valid;
        end
      end
      @(negedge clock);
      if (!rand_mode && bus.mem_req_valid) begin
        mreq_vld_cycles++;
        if (!prev_mvld) mreq_cyc = cyc;
        if (exp_req.size() == 0) begin
          check("mem_req_unexpected", 64'(bus.mem_req_valid), 64'd0);
        end else begin
          check("mem_req_addr", 64'(bus.mem_req_bits_addr), 64'(exp_req[0].addr));
          check("mem_req_data", 64'(bus.mem_req_bits_data), 64'(exp_req[0].data));
          check("mem_req_fcn_typ", 64'({bus.mem_req_bits_fcn, bus.mem_req_bits_typ}),
                64'({exp_req[0].fcn, exp_req[0].typ}));
        end
        if (bus.mem_req_ready) begin
          if (bus.mem_req_bits_fcn) begin
            mem_arr[bus.mem_req_bits_addr] = bus.mem_req_bits_data;
            rsp_data = '0;
          end else begin
            rsp_data = mem_arr.exists(bus.mem_req_bits_addr) ? mem_arr[bus.mem_req_bits_addr] : 32'hBAD0_0000;
          end
          rsp_wait = resp_delay;
          if (exp_req.size() > 0) void'(exp_req.pop_front());
        end
      end
      prev_mvld = bus.mem_req_valid;
    end
  end

  // Response monitor: pops the scoreboard whenever either port presents a response
  initial forever begin
    rsp_t e;
    logic [1:0] seen;
    @(negedge clock);
    seen = {bus.io_imem_resp_valid, bus.io_dmem_resp_valid};
    if (!reset && seen != 2'b00) begin
      if (bus.io_imem_resp_valid) begin imem_rsp_cnt++; imem_resp_cyc = cyc; end
      if (bus.io_dmem_resp_valid) dmem_rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        check("resp_unexpected", 64'(seen), 64'd0);
      end else begin
        e = exp_rsp.pop_front();
        check("resp_port", 64'(seen), e.is_d ? 64'd1 : 64'd2);
        if (e.chk)
          check("resp_data", 64'(e.is_d ? bus.io_dmem_resp_bits_data : bus.io_imem_resp_bits_data),
                64'(e.data));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d_addr [6];
    logic [31:0] d_data [6];
    int ic0, dc0;
    d_addr = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
    d_data = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004, 32'hD000_0005};
    mem_arr[32'h100]  = 32'h0020_0313;
    mem_arr[32'h104]  = 32'h0000_0013;
    mem_arr[32'h1000] = 32'h1100_0001;
    mem_arr[32'h1004] = 32'h1100_0002;
    for (int i = 0; i < 6; i++) mem_arr[d_addr[i]] = d_data[i];

    // 1: reset with random inputs
    rand_mode = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("t1_reset_outputs_zero", out_flags(), 64'd0);
    end
    rand_mode = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check("t1_err_after_reset", 64'(err), 64'd0);
    check("t1_no_mem_req", 64'(bus.mem_req_valid), 64'd0);

    // 2: imem alone, 1-cycle memory
    expect_txn(1'b0, 32'h100, 32'h0, 1'b0, 3'd0, 32'h0020_0313, 1'b1);
    imem_q.push_back(32'h100);
    wait_done("t2", 20);
    check("t2_mreq_latency", 64'(mreq_cyc - imem_gnt_cyc), 64'd1);
    check("t2_resp_latency", 64'(imem_resp_cyc - imem_gnt_cyc), 64'd2);

    // 3: dmem store with ready stalled for 4 cycles
    stall_left = 4;
    mreq_vld_cycles = 0;
    ic0 = imem_rsp_cnt;
    dc0 = dmem_rsp_cnt;
    expect_txn(1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b1, 3'd3, 32'h0, 1'b0);
    dmem_q.push_back('{addr: 32'h2000, data: 32'hDEAD_BEEF, fcn: 1'b1, typ: 3'd3});
    wait_done("t3", 30);
    check("t3_req_hold_cycles", 64'(mreq_vld_cycles), 64'd5);
    check("t3_dmem_resp_count", 64'(dmem_rsp_cnt - dc0), 64'd1);
    check("t3_imem_resp_count", 64'(imem_rsp_cnt - ic0), 64'd0);

    // 4: both valid every cycle; imem forced through after three lost conflicts
    gnt_cyc.delete();
    expect_txn(1'b1, 32'h3000, 32'h0, 1'b0, 3'd2, 32'hD000_0000, 1'b1);
    expect_txn(1'b1, 32'h3004, 32'h0, 1'b0, 3'd2, 32'hD000_0001, 1'b1);
    expect_txn(1'b1, 32'h3008, 32'h0, 1'b0, 3'd2, 32'hD000_0002, 1'b1);
    expect_txn(1'b0, 32'h1000, 32'h0, 1'b0, 3'd0, 32'h1100_0001, 1'b1);
    expect_txn(1'b1, 32'h300C, 32'h0, 1'b0, 3'd2, 32'hD000_0003, 1'b1);
    expect_txn(1'b1, 32'h3010, 32'h0, 1'b0, 3'd2, 32'hD000_0004, 1'b1);
    expect_txn(1'b1, 32'h3014, 32'h0, 1'b0, 3'd2, 32'hD000_0005, 1'b1);
    expect_txn(1'b0, 32'h1004, 32'h0, 1'b0, 3'd0, 32'h1100_0002, 1'b1);
    for (int i = 0; i < 6; i++)
      dmem_q.push_back('{addr: d_addr[i], data: 32'h0, fcn: 1'b0, typ: 3'd2});
    imem_q.push_back(32'h1000);
    imem_q.push_back(32'h1004);
    wait_done("t4", 80);
    check("t4_grant_count", 64'(gnt_cyc.size()), 64'd8);
    for (int i = 1; i < gnt_cyc.size(); i++)
      check("t4_grant_spacing", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd3);
    check("t4_err_clear", 64'(err), 64'd0);

    // 5: spurious response in IDLE
    spur_req = 1'b1;
    repeat (2) @(negedge clock);
    check("t5_err_set", 64'(err), 64'd1);
    repeat (3) @(negedge clock);
    check("t5_err_sticky", 64'(err), 64'd1);
    expect_txn(1'b1, 32'h2000, 32'h0, 1'b0, 3'd3, 32'hDEAD_BEEF, 1'b1);
    dmem_q.push_back('{addr: 32'h2000, data: 32'h0, fcn: 1'b0, typ: 3'd3});
    wait_done("t5", 20);
    check("t5_err_after_txn", 64'(err), 64'd1);

    // 6: reset while in RESP, then a late response
    resp_delay = 4;
    exp_req.push_back('{addr: 32'h300, data: 32'h0, fcn: 1'b0, typ: 3'd0});
    imem_q.push_back(32'h300);
    begin
      int n;
      n = 0;
      while (!(bus.mem_req_valid && bus.mem_req_ready) && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("t6_accepted", 64'(bus.mem_req_valid && bus.mem_req_ready), 64'd1);
    end
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("t6_reset_outputs_zero", out_flags(), 64'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check("t6_err_cleared", 64'(err), 64'd0);
    wait_done("t6", 20);
    check("t6_late_resp_err", 64'(err), 64'd1);
    resp_delay = 1;
    expect_txn(1'b0, 32'h104, 32'h0, 1'b0, 3'd0, 32'h0000_0013, 1'b1);
    imem_q.push_back(32'h104);
    wait_done("t6b", 20);
    check("t6_err_still_set", 64'(err), 64'd1);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
